// File: rtl/timer_pkg.sv
// Shared definitions for the timer_dev peripheral: bus offsets, CTRL bit
// positions, mode encodings and the timer state enum.
package timer_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } timer_state_e;

endpackage

// File: rtl/timer_dev.sv
// Programmable down-counting timer with masked, registered interrupt output.
// Define TIMER_AUTORELOAD_EN to implement mode 1 (periodic auto-reload).
module timer_dev #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);
  import timer_pkg::*;

  timer_state_e         state, state_next;
  logic                 ctrl_en;
  logic [1:0]           ctrl_mode;
  logic                 ctrl_im;
  logic [COUNT_W-1:0]   preset;
  logic [COUNT_W-1:0]   count;
  logic                 flag;
  logic                 wr_ctrl, wr_preset, reload_mode;
  logic                 do_load, do_dec, set_flag, int_done;

  assign wr_ctrl   = we && (addr == OFF_CTRL);
  assign wr_preset = we && (addr == OFF_PRESET);

`ifdef TIMER_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (reset)
      ctrl_mode <= '0;
    else if (wr_ctrl)
      ctrl_mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
  end

  // Modes 2 and 3 fall back to one-shot behaviour.
  assign reload_mode = (ctrl_mode == MODE_RELOAD);
`else
  assign ctrl_mode   = '0;
  assign reload_mode = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (ctrl_en) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_CNT;
      ST_CNT: begin
        if (!ctrl_en)
          state_next = ST_IDLE;
        else if (count == '0)
          state_next = ST_INT;
      end
      ST_INT:  state_next = reload_mode ? ST_LOAD : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    do_load  = (state == ST_LOAD);
    do_dec   = (state == ST_CNT) && ctrl_en && (count != '0);
    set_flag = (state == ST_CNT) && ctrl_en && (count == '0);
    int_done = (state == ST_INT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en <= 1'b0;
      ctrl_im <= 1'b0;
      preset  <= '0;
      count   <= '0;
      flag    <= 1'b0;
      irq     <= 1'b0;
    end else begin
      // A software CTRL write overrides the hardware one-shot ENABLE clear.
      if (wr_ctrl) begin
        ctrl_en <= din[CTRL_ENABLE];
        ctrl_im <= din[CTRL_IM];
      end else if (int_done && !reload_mode) begin
        ctrl_en <= 1'b0;
      end

      if (wr_preset)
        preset <= din[COUNT_W-1:0];

      if (do_load)
        count <= preset;
      else if (do_dec)
        count <= count - COUNT_W'(1);

      if (set_flag)
        flag <= 1'b1;
      else if (wr_ctrl || wr_preset || (int_done && reload_mode))
        flag <= 1'b0;

      irq <= flag & ctrl_im;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      OFF_CTRL: begin
        dout[CTRL_ENABLE]                = ctrl_en;
        dout[CTRL_MODE_HI:CTRL_MODE_LO]  = ctrl_mode;
        dout[CTRL_IM]                    = ctrl_im;
      end
      OFF_PRESET: dout = 32'(preset);
      OFF_COUNT:  dout = 32'(count);
      default:    dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register table, directed corner
// sequences and randomized trials against a closed-form timeline model.
module tb_timer_dev;
  import timer_pkg::*;

`ifdef TIMER_AUTORELOAD_EN
  localparam bit RELOAD_EN = 1'b1;
`else
  localparam bit RELOAD_EN = 1'b0;
`endif
  localparam logic [31:0] MODE_MASK = RELOAD_EN ? 32'h6 : 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  timer_dev #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = dout;
  endtask

  task automatic do_reset();
    we = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Timeline model: k counts edges after the enabling CTRL write (k=0).
  // COUNT loads at k=2, expiry flag appears at k=p+3, reload period p+3.
  function automatic int m_count(int p, bit rl, int d, int k);
    int j;
    if (k >= d) return p - (d - 2);
    if (k < 2) return 0;
    if (rl) begin
      j = (k - 2) % (p + 3);
      return (j <= p) ? p - j : 0;
    end
    return (k - 2 <= p) ? p - (k - 2) : 0;
  endfunction

  function automatic bit m_flag(int p, bit rl, int d, int k);
    if (k >= d || k < 2) return 1'b0;
    if (rl) return ((k - 2) % (p + 3)) == p + 1;
    return k >= p + 3;
  endfunction

  function automatic bit m_en(int p, bit rl, int d, int k);
    if (k >= d) return 1'b0;
    if (rl) return 1'b1;
    return k <= p + 3;
  endfunction

  initial begin
    logic [31:0] v;
    logic        seen;

    vecs[0] = '{1'b1, OFF_PRESET, 32'hA5A5_1234, OFF_PRESET, 32'hA5A5_1234};
    vecs[1] = '{1'b1, OFF_COUNT,  32'h0000_FFFF, OFF_COUNT,  32'h0};
    vecs[2] = '{1'b1, 2'd3,       32'h0000_1234, 2'd3,       32'h0};
    vecs[3] = '{1'b0, OFF_CTRL,   32'h0,         OFF_PRESET, 32'hA5A5_1234};
    vecs[4] = '{1'b1, OFF_CTRL,   32'hFFFF_FFFE, OFF_CTRL,   32'h8 | MODE_MASK};
    vecs[5] = '{1'b1, OFF_CTRL,   32'h0000_0004, OFF_CTRL,   32'h4 & MODE_MASK};
    vecs[6] = '{1'b1, OFF_PRESET, 32'h0,         OFF_PRESET, 32'h0};

    // Reset state
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check($sformatf("reset_dout%0d", a), v, 32'h0);
    end
    check("reset_irq", 32'(irq), 32'h0);

    // Register access table (ENABLE kept 0)
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].we) bus_write(vecs[i].waddr, vecs[i].wdata);
      else tick();
      rd(vecs[i].raddr, v);
      check($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // One-shot, PRESET=5, IM set
    do_reset();
    bus_write(OFF_PRESET, 32'd5);
    bus_write(OFF_CTRL, 32'h9);
    repeat (8) tick();
    check("oneshot_irq_before", 32'(irq), 32'h0);
    tick();
    check("oneshot_irq_rise", 32'(irq), 32'h1);
    rd(OFF_CTRL, v);
    check("oneshot_ctrl", v, 32'h8);
    bus_write(OFF_CTRL, 32'h8);
    check("oneshot_irq_hold", 32'(irq), 32'h1);
    tick();
    check("oneshot_irq_drop", 32'(irq), 32'h0);

    // Disable mid-count, then re-enable
    do_reset();
    bus_write(OFF_PRESET, 32'd10);
    bus_write(OFF_CTRL, 32'h9);
    repeat (7) tick();
    rd(OFF_COUNT, v);
    check("disable_cnt_before", v, 32'd5);
    bus_write(OFF_CTRL, 32'h8);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= irq;
    end
    rd(OFF_COUNT, v);
    check("disable_cnt_hold", v, 32'd4);
    check("disable_no_irq", 32'(seen), 32'h0);
    bus_write(OFF_CTRL, 32'h9);
    tick();
    rd(OFF_COUNT, v);
    check("reenable_load_cnt", v, 32'd4);
    tick();
    rd(OFF_COUNT, v);
    check("reenable_reload", v, 32'd10);

    // PRESET=0 with IM clear: flag is masked, then cleared by a CTRL write
    do_reset();
    bus_write(OFF_PRESET, 32'd0);
    bus_write(OFF_CTRL, 32'h1);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= irq;
    end
    check("masked_irq", 32'(seen), 32'h0);
    rd(OFF_CTRL, v);
    check("masked_expired_ctrl", v, 32'h0);
    bus_write(OFF_CTRL, 32'h8);
    seen = irq;
    repeat (4) begin
      tick();
      seen |= irq;
    end
    check("masked_flag_cleared", 32'(seen), 32'h0);

    // Reset mid-count
    do_reset();
    bus_write(OFF_PRESET, 32'd10);
    bus_write(OFF_CTRL, 32'h9);
    repeat (5) tick();
    rd(OFF_COUNT, v);
    check("midreset_cnt_before", v, 32'd7);
    do_reset();
    for (int a = 0; a < 3; a++) begin
      rd(2'(a), v);
      check($sformatf("midreset_dout%0d", a), v, 32'h0);
    end
    bus_write(OFF_COUNT, 32'h55);
    repeat (3) tick();
    rd(OFF_COUNT, v);
    check("midreset_count_wr_ignored", v, 32'h0);

    // Reset with irq pending
    do_reset();
    bus_write(OFF_PRESET, 32'd0);
    bus_write(OFF_CTRL, 32'h9);
    repeat (4) tick();
    check("pending_irq", 32'(irq), 32'h1);
    do_reset();
    check("pending_irq_reset", 32'(irq), 32'h0);
    rd(OFF_CTRL, v);
    check("pending_ctrl_reset", v, 32'h0);

    // Randomized trials; first one is PRESET=3, mode 1, IM set
    for (int t = 0; t < 25; t++) begin
      int p, d, n, ec;
      logic [1:0] mode;
      logic im;
      bit rl, ef, ee, prev_flag;
      p    = (t == 0) ? 3 : int'($urandom_range(0, 9));
      mode = (t == 0) ? 2'd1 : 2'($urandom_range(0, 3));
      im   = (t == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      d    = 1000;
      if (t != 0 && p >= 1 && $urandom_range(0, 2) == 0)
        d = int'($urandom_range(3, p + 2));
      rl = RELOAD_EN && (mode == 2'd1);
      n  = 2 * (p + 3) + 6;
      do_reset();
      bus_write(OFF_PRESET, 32'(p));
      bus_write(OFF_CTRL, {28'h0, im, mode, 1'b1});
      prev_flag = 1'b0;
      for (int k = 0; k <= n; k++) begin
        we = 1'b0;
        ec = m_count(p, rl, d, k);
        ee = m_en(p, rl, d, k);
        ef = im && prev_flag;
        rd(OFF_COUNT, v);
        check($sformatf("rnd%0d_k%0d_count", t, k), v, 32'(ec));
        rd(OFF_CTRL, v);
        check($sformatf("rnd%0d_k%0d_ctrl", t, k), v,
              {28'h0, im, (RELOAD_EN ? mode : 2'b00), ee});
        check($sformatf("rnd%0d_k%0d_irq", t, k), 32'(irq), 32'(ef));
        prev_flag = m_flag(p, rl, d, k);
        if (k + 1 == d) begin
          we = 1'b1; addr = OFF_CTRL; din = {28'h0, im, mode, 1'b0};
        end
        tick();
      end
      we = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
# timer_dev

Programmable down-counting timer peripheral on the system bridge. It is the interrupt source that drives one bit of the CPU coprocessor's `hwint[5:0]` vector. Software programs it with word loads and stores through the bridge. It raises `irq` when the count expires, either once (mode 0) or periodically with auto-reload (mode 1).

## Interface
Parameters:
- `COUNT_W`, default 32: PRESET/COUNT register width; zero-extended to 32 on read.

Ports:
- `clk`  in  1: clock
- `reset`  in  1: synchronous, active-high reset
- `addr`  in  2: word offset (bridge address[3:2]); 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- `we`  in  1: write strobe, sampled on posedge clk
- `din`  in  32: write data
- `dout`  out  32: combinational read of the register selected by `addr`; reserved offset reads 0
- `irq`  out  1: interrupt request to CP0 `hwint`, registered

## Operation
- CTRL[0] ENABLE, CTRL[2:1] MODE, CTRL[3] IM (irq mask). CTRL[31:4] read 0.
- PRESET is read/write. COUNT is read-only; writes to COUNT and to offset 3 are ignored.
- MODE 2 and 3 behave as mode 0.
- The state machine has four states: IDLE, LOAD, CNT, INT.
- IDLE: if ENABLE, go to LOAD.
- LOAD: COUNT <= PRESET, go to CNT.
- CNT:
  - If ENABLE=0, go to IDLE with COUNT frozen.
  - Else if COUNT != 0, COUNT <= COUNT-1.
  - Else go to INT and set the internal flag.
- INT, mode 0: hardware clears ENABLE, go to IDLE. The flag stays set until any bus write to CTRL or PRESET.
- INT, mode 1: clear the flag, go to LOAD. The flag is therefore high for exactly one cycle per period.
- `irq` <= flag & IM, registered.
- Simultaneous events:
  - A bus write to CTRL in the same cycle as the hardware ENABLE clear: the bus write wins.
  - A PRESET write during CNT affects only the next LOAD.
- PRESET=0: COUNT loads 0, and the next CNT cycle goes straight to INT.
- Reset mid-count: all registers, the flag and `irq` go to 0, and the state goes to IDLE on that edge.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, flag=0, `irq`=0, state=IDLE. `dout` reads 0 at every offset after reset.
- Writes take effect on the posedge where `we`=1. Reads show the new value in the following cycle.
- Start-up, with ENABLE written on edge E0 and PRESET=P:
  - E1: IDLE to LOAD.
  - E2: COUNT=P, enter CNT.
  - E(2+P): COUNT reaches 0.
  - E(3+P): enter INT, flag set.
  - E(4+P): `irq` high.
- Mode 1 period: P+3 cycles. `irq` pulses for 1 cycle each period.
- Disabling during CNT: the state is IDLE after the next edge, and COUNT holds its value.
- Re-enabling from IDLE always passes through LOAD, so the count restarts from PRESET.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: mode 1 (auto-reload) is implemented as described.
- Undefined:
  - CTRL[2:1] is not stored and reads 0.
  - All expirations follow mode 0.
  - The INT-to-LOAD path is absent.

## Structure
- Shared package `timer_pkg` holds:
  - register offsets (CTRL/PRESET/COUNT)
  - CTRL bit positions (ENABLE, MODE, IM)
  - mode encodings
  - state enum (IDLE/LOAD/CNT/INT)
- Single module; no sub-module needed. The register file and the state machine are small enough to sit together.

## Test plan
1. Reset, then read offsets 0..3 -> `dout`=0 each; `irq`=0.
2. Write PRESET=5, then CTRL=0x9 (enable, mode 0, IM) at edge E0 -> `irq` rises after E9; CTRL reads 0x8; `irq` stays high until a CTRL write of 0x8, then drops one cycle later.
3. With `TIMER_AUTORELOAD_EN`: PRESET=3, CTRL=0xB -> `irq` is a one-cycle pulse every 6 cycles; COUNT reads 3,2,1,0 in sequence. Without the macro -> a single expiration; CTRL reads 0x8.
4. PRESET=10, enable; write CTRL=0x8 while COUNT=4 -> COUNT holds 4, no `irq`. Re-enable -> COUNT reloads 10.
5. PRESET=0, CTRL=0x1 (IM=0) -> flag set after E3 but `irq` stays 0. Then write CTRL=0x8 -> that write clears the flag, so `irq` remains 0.
6. Assert `reset` while COUNT=7 with `irq` pending -> the next cycle shows all registers 0, `irq`=0, state IDLE; a write to COUNT is ignored.
